// File: rtl/vid_axis_src.sv
// AXI4-Stream test pattern source: frames of hsize x vsize beats, tuser=SOF, tlast=EOL; optional inter-frame gap via VID_SRC_FRAME_GAP_EN.
// Latency: first beat valid one cycle after enable is seen in IDLE; back-to-back frames without a bubble when enabled.
// Backpressure: tready low freezes x/y/state and holds tvalid/tdata/tlast/tuser stable until the handshake.
module vid_axis_src #(
    parameter int MAX_HSIZE  = 1920,
    parameter int MAX_VSIZE  = 1080,
    parameter int DATA_WIDTH = 24
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          enable,
`ifdef VID_SRC_FRAME_GAP_EN
    input  logic [15:0]                   gap_cycles,
`endif
    input  logic [$clog2(MAX_HSIZE):0]    hsize,
    input  logic [$clog2(MAX_VSIZE):0]    vsize,
    input  logic [1:0]                    pattern,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [31:0]                   frame_cnt,
    output logic                          busy
);

    localparam int HW = $clog2(MAX_HSIZE) + 1;
    localparam int VW = $clog2(MAX_VSIZE) + 1;
    localparam int C  = DATA_WIDTH / 3;
    localparam logic [HW-1:0] H_MAX = HW'(MAX_HSIZE);
    localparam logic [VW-1:0] V_MAX = VW'(MAX_VSIZE);
    localparam logic [HW-1:0] H_ONE = HW'(1);
    localparam logic [VW-1:0] V_ONE = VW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE
`ifdef VID_SRC_FRAME_GAP_EN
        ,S_GAP
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [HW-1:0]         x_q, x_d, hsize_l_q, hsize_l_d;
    logic [VW-1:0]         y_q, y_d, vsize_l_q, vsize_l_d;
    logic [1:0]            pat_l_q, pat_l_d;
    logic [31:0]           frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic                  busy_q, busy_d;
`ifdef VID_SRC_FRAME_GAP_EN
    logic [15:0]           gap_cnt_q, gap_cnt_d;
`endif
    logic                  start_frame;
    logic                  next_beat;
    logic                  last_x, last_y;

    function automatic logic [HW-1:0] clamp_h(input logic [HW-1:0] v);
        if (v == '0)
            return H_ONE;
        else if (v > H_MAX)
            return H_MAX;
        return v;
    endfunction

    function automatic logic [VW-1:0] clamp_v(input logic [VW-1:0] v);
        if (v == '0)
            return V_ONE;
        else if (v > V_MAX)
            return V_MAX;
        return v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pix(input logic [HW-1:0] px, input logic [VW-1:0] py,
                                                  input logic [1:0] pat, input logic [31:0] fc);
        logic [31:0] v;
        v = '0;
        case (pat)
            2'd0:    v = 32'(px);
            2'd1:    v = 32'(py);
            2'd2:    v = (px[3] ^ py[3]) ? '1 : '0;
            default: v = fc;
        endcase
        return {3{v[C-1:0]}};
    endfunction

    assign last_x = (x_q == hsize_l_q - H_ONE);
    assign last_y = (y_q == vsize_l_q - V_ONE);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        hsize_l_d   = hsize_l_q;
        vsize_l_d   = vsize_l_q;
        pat_l_d     = pat_l_q;
        frame_cnt_d = frame_cnt_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        busy_d      = busy_q;
`ifdef VID_SRC_FRAME_GAP_EN
        gap_cnt_d   = gap_cnt_q;
`endif
        start_frame = 1'b0;
        next_beat   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable)
                    start_frame = 1'b1;
            end
            S_ACTIVE: begin
                if (tvalid_q && m_axis_tready) begin
                    if (!last_x) begin
                        x_d       = x_q + H_ONE;
                        next_beat = 1'b1;
                    end else if (!last_y) begin
                        x_d       = '0;
                        y_d       = y_q + V_ONE;
                        next_beat = 1'b1;
                    end else begin
                        x_d         = '0;
                        y_d         = '0;
                        frame_cnt_d = frame_cnt_q + 32'd1;
`ifdef VID_SRC_FRAME_GAP_EN
                        if (gap_cycles != 16'd0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_cycles - 16'd1;
                            tvalid_d  = 1'b0;
                        end else
`endif
                        if (enable) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d  = S_IDLE;
                            tvalid_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    end
                end
            end
`ifdef VID_SRC_FRAME_GAP_EN
            S_GAP: begin
                // Count runs N-1..0 so the gap is exactly N cycles before the next SOF.
                if (gap_cnt_q != 16'd0) begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end else if (enable) begin
                    start_frame = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (start_frame) begin
            hsize_l_d = clamp_h(hsize);
            vsize_l_d = clamp_v(vsize);
            pat_l_d   = pattern;
            x_d       = '0;
            y_d       = '0;
            state_d   = S_ACTIVE;
            tvalid_d  = 1'b1;
            busy_d    = 1'b1;
            next_beat = 1'b1;
        end

        // Beat fields come from next-cycle coordinates so every output stays a flop.
        if (next_beat) begin
            tdata_d = pix(x_d, y_d, pat_l_d, frame_cnt_d);
            tlast_d = (x_d == hsize_l_d - H_ONE);
            tuser_d = (x_d == '0) && (y_d == '0);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            hsize_l_q   <= H_ONE;
            vsize_l_q   <= V_ONE;
            pat_l_q     <= '0;
            frame_cnt_q <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef VID_SRC_FRAME_GAP_EN
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hsize_l_q   <= hsize_l_d;
            vsize_l_q   <= vsize_l_d;
            pat_l_q     <= pat_l_d;
            frame_cnt_q <= frame_cnt_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            busy_q      <= busy_d;
`ifdef VID_SRC_FRAME_GAP_EN
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign frame_cnt     = frame_cnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_vid_axis_src.sv
// Scoreboard bench for vid_axis_src: stimulus pushes expected beats, a negedge monitor pops and compares on each handshake.
module tb_vid_axis_src;

    localparam int DW = 24;
    localparam int HW = 12;
    localparam int VW = 12;

    logic          aclk    = 1'b0;
    logic          areset  = 1'b1;
    logic          enable  = 1'b0;
    logic [HW-1:0] hsize   = 12'd4;
    logic [VW-1:0] vsize   = 12'd3;
    logic [1:0]    pattern = 2'd0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready  = 1'b1;
    logic          tlast;
    logic          tuser;
    logic [31:0]   frame_cnt;
    logic          busy;
`ifdef VID_SRC_FRAME_GAP_EN
    logic [15:0]   gap_cycles = 16'd0;
`endif

    vid_axis_src #(.MAX_HSIZE(1920), .MAX_VSIZE(1080), .DATA_WIDTH(DW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
`ifdef VID_SRC_FRAME_GAP_EN
        .gap_cycles    (gap_cycles),
`endif
        .hsize         (hsize),
        .vsize         (vsize),
        .pattern       (pattern),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .frame_cnt     (frame_cnt),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            hs_cnt = 0;
    bit            rnd_rdy = 1'b0;
    logic [DW+1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW+1:0] exp_beat(input int x, input int y, input int h, input int pat, input int fc);
        logic [7:0] c;
        case (pat)
            0:       c = x[7:0];
            1:       c = y[7:0];
            2:       c = (x[3] ^ y[3]) ? 8'hff : 8'h00;
            default: c = fc[7:0];
        endcase
        return {c, c, c, (x == h - 1), (x == 0 && y == 0)};
    endfunction

    task automatic push_frame(input int h, input int v, input int pat, input int fc);
        for (int y = 0; y < v; y++)
            for (int x = 0; x < h; x++)
                exp_q.push_back(exp_beat(x, y, h, pat, fc));
    endtask

    // tready source: random in backpressure sections, otherwise held high.
    always @(posedge aclk) begin
        #1;
        tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: sampled on the falling edge, mid-cycle.
    logic          stall_p = 1'b0;
    logic [DW+1:0] held;
    always @(negedge aclk) begin
        if (areset) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("hold_tvalid", tvalid, 1);
                chk("hold_beat", {tdata, tlast, tuser}, held);
            end
            if (tvalid && tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat at %0t", {tdata, tlast, tuser}, $time);
                end else begin
                    chk("beat", {tdata, tlast, tuser}, exp_q.pop_front());
                end
            end
            stall_p = tvalid && !tready;
            held    = {tdata, tlast, tuser};
        end
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, hs_cnt, target);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!tvalid && n < budget) begin
            tick();
            n++;
        end
        chk(name, tvalid, 1);
    endtask

    initial begin
        #500_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gap_n;

        // Reset state
        tick();
        tick();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        areset = 1'b0;
        tick();
        chk("idle_tvalid", tvalid, 0);

        // 4x3 h-ramp, two frames back to back
        base = hs_cnt;
        hsize = 12'd4; vsize = 12'd3; pattern = 2'd0;
        push_frame(4, 3, 0, 0);
        push_frame(4, 3, 0, 1);
        enable = 1'b1;
        wait_hs(base + 12, 100, "t2_first_frame");
        chk("t2_frame_cnt", frame_cnt, 1);
        chk("t2_next_sof_valid", tvalid, 1);
        chk("t2_next_sof_tuser", tuser, 1);
        chk("t2_busy", busy, 1);
        enable = 1'b0;
        wait_hs(base + 24, 100, "t2_second_frame");
        chk("t2_end_tvalid", tvalid, 0);
        chk("t2_end_busy", busy, 0);
        chk("t2_end_frame_cnt", frame_cnt, 2);

        // Backpressure with checkerboard
        rnd_rdy = 1'b1;
        base = hs_cnt;
        hsize = 12'd8; vsize = 12'd2; pattern = 2'd2;
        push_frame(8, 2, 2, 0);
        enable = 1'b1;
        wait_valid(10, "t3_sof");
        enable = 1'b0;
        wait_hs(base + 16, 400, "t3_8x2_beats");
        base = hs_cnt;
        hsize = 12'd16; vsize = 12'd9;
        push_frame(16, 9, 2, 0);
        enable = 1'b1;
        wait_valid(10, "t3b_sof");
        enable = 1'b0;
        wait_hs(base + 144, 2000, "t3_16x9_beats");
        rnd_rdy = 1'b0;
        tick();
        tick();
        chk("t3_frame_cnt", frame_cnt, 4);
        chk("t3_idle_tvalid", tvalid, 0);

        // Asynchronous reset in the middle of a frame
        base = hs_cnt;
        hsize = 12'd4; vsize = 12'd3; pattern = 2'd3;
        push_frame(4, 3, 3, 4);
        enable = 1'b1;
        wait_hs(base + 5, 50, "t1_pre_reset_beats");
        enable = 1'b0;
        @(posedge aclk);
        #3;
        areset = 1'b1;
        #1;
        chk("t1_async_tvalid", tvalid, 0);
        chk("t1_async_tuser", tuser, 0);
        chk("t1_async_tlast", tlast, 0);
        chk("t1_async_frame_cnt", frame_cnt, 0);
        chk("t1_async_busy", busy, 0);
        exp_q.delete();
        tick();
        areset = 1'b0;
        tick();

        // enable dropped at beat 5 of a 4x3 v-ramp frame
        base = hs_cnt;
        hsize = 12'd4; vsize = 12'd3; pattern = 2'd1;
        push_frame(4, 3, 1, 0);
        enable = 1'b1;
        wait_hs(base + 5, 50, "t4_beat5");
        enable = 1'b0;
        wait_hs(base + 12, 50, "t4_frame_done");
        chk("t4_tvalid", tvalid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_frame_cnt", frame_cnt, 1);
        repeat (5) tick();
        chk("t4_no_extra_beats", hs_cnt, base + 12);

        // 1x1 frames, solid frame_cnt pattern
        base = hs_cnt;
        hsize = 12'd1; vsize = 12'd1; pattern = 2'd3;
        push_frame(1, 1, 3, 1);
        push_frame(1, 1, 3, 2);
        push_frame(1, 1, 3, 3);
        enable = 1'b1;
        wait_hs(base + 2, 20, "t5_two_frames");
        enable = 1'b0;
        wait_hs(base + 3, 20, "t5_three_frames");
        chk("t5_1x1_frame_cnt", frame_cnt, 4);
        chk("t5_1x1_tvalid", tvalid, 0);

        // hsize=0 behaves as 1
        base = hs_cnt;
        hsize = 12'd0; vsize = 12'd2; pattern = 2'd1;
        push_frame(1, 2, 1, 0);
        enable = 1'b1;
        wait_valid(10, "t5_h0_sof");
        enable = 1'b0;
        wait_hs(base + 2, 20, "t5_h0_beats");
        chk("t5_h0_frame_cnt", frame_cnt, 5);

        // hsize above maximum clamps to 1920
        base = hs_cnt;
        hsize = 12'd4000; vsize = 12'd1; pattern = 2'd0;
        push_frame(1920, 1, 0, 0);
        enable = 1'b1;
        wait_valid(10, "t5_clamp_sof");
        enable = 1'b0;
        wait_hs(base + 1920, 2500, "t5_clamp_beats");
        tick();
        chk("t5_clamp_frame_cnt", frame_cnt, 6);
        chk("t5_clamp_tvalid", tvalid, 0);

`ifdef VID_SRC_FRAME_GAP_EN
        // Inter-frame gap of 5 cycles, then gap of 0
        base = hs_cnt;
        hsize = 12'd2; vsize = 12'd2; pattern = 2'd0;
        gap_cycles = 16'd5;
        push_frame(2, 2, 0, 0);
        push_frame(2, 2, 0, 0);
        enable = 1'b1;
        wait_hs(base + 4, 20, "t6_gap_first");
        chk("t6_gap_busy", busy, 1);
        gap_n = 0;
        while (!tvalid && gap_n < 20) begin
            gap_n++;
            tick();
        end
        chk("t6_gap_len", gap_n, 5);
        chk("t6_gap_sof", tuser, 1);
        enable = 1'b0;
        wait_hs(base + 8, 20, "t6_gap_second");
        repeat (8) tick();
        chk("t6_gap_idle_busy", busy, 0);
        base = hs_cnt;
        gap_cycles = 16'd0;
        push_frame(2, 2, 0, 0);
        push_frame(2, 2, 0, 0);
        enable = 1'b1;
        wait_hs(base + 4, 20, "t6_nogap_first");
        chk("t6_nogap_tvalid", tvalid, 1);
        chk("t6_nogap_tuser", tuser, 1);
        enable = 1'b0;
        wait_hs(base + 8, 20, "t6_nogap_second");
`endif

        repeat (4) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
